// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: load-FSM encoding, instruction word layout
// and the byte-order / R-type constants that cpu_core also relies on.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        ISSUE   = 2'd2,
        LOCKOUT = 2'd3
    } load_state_e;

    localparam int BYTE_W      = 8;
    localparam int OPCODE_W    = 4;
    localparam int INSTR_W     = 12;
    localparam int HI_BYTE_LSB = 8;  // HI byte = {opcode, instr[11:8]}
    localparam int LO_BYTE_LSB = 0;
    localparam int RTYPE_BIT   = 3;  // opcode[3]: 1 = R-type, 0 = I-type

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [INSTR_W-1:0]  instr;
    } instr_word_t;

    function automatic instr_word_t assemble_word(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
        logic [OPCODE_W+INSTR_W-1:0] raw;
        raw = '0;
        raw[HI_BYTE_LSB +: BYTE_W] = hi;
        raw[LO_BYTE_LSB +: BYTE_W] = lo;
        return instr_word_t'(raw);
    endfunction

    function automatic logic is_rtype(input logic [OPCODE_W-1:0] op);
        return op[RTYPE_BIT];
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Pin-side bundle of the instruction loader: switch bank and button in, core-facing outputs.
// master = board/stimulus side, slave = the loader itself.
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic [BYTE_W-1:0]   data_in;
    logic                btn_raw;
    logic [OPCODE_W-1:0] opcode;
    logic [INSTR_W-1:0]  instr;
    logic                inst_done;
    logic                btn_edge;
    logic                busy;

    modport master (
        output data_in, btn_raw,
        input  opcode, instr, inst_done, btn_edge, busy
    );

    modport slave (
        input  data_in, btn_raw,
        output opcode, instr, inst_done, btn_edge, busy
    );

endinterface

// File: rtl/instr_loader_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a registered
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
    import instr_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic btn_edge_o
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta_q;
    logic             btn_s_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a path
        // that skips the assignment infers a latch.
        cnt_d    = '0;
        stable_d = stable_q;
        if (btn_s_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta_q  <= 1'b0;
            btn_s_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            edge_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, which is
            // what makes the two synchronizer stages a real pipeline rather than one wire.
            sync_meta_q  <= btn_raw_i;
            btn_s_q      <= sync_meta_q;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edge_q       <= stable_q & ~stable_dly_q;
        end
    end

    assign btn_edge_o = edge_q;

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: two debounced presses capture HI then LO switch bytes, the word is issued
// to cpu_core with a one-cycle inst_done, then new captures are locked out while it executes.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EXEC_LOCKOUT    = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_loader_if.slave  ld_if
);

    localparam int              LOCK_W   = cnt_width(EXEC_LOCKOUT);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(EXEC_LOCKOUT - 1);

    logic              btn_edge;
    load_state_e       state_q;
    logic [BYTE_W-1:0] stage_hi_q;
    logic [BYTE_W-1:0] stage_lo_q;
    instr_word_t       word_q;
    logic              inst_done_q;
    logic [LOCK_W-1:0] lock_cnt_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_i  (ld_if.btn_raw),
        .btn_edge_o (btn_edge)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_HI;
            stage_hi_q  <= '0;
            stage_lo_q  <= '0;
            word_q      <= '0;
            inst_done_q <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            inst_done_q <= 1'b0;
            case (state_q)
                WAIT_HI: begin
                    if (btn_edge) begin
                        stage_hi_q <= ld_if.data_in;
                        state_q    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (btn_edge) begin
                        stage_lo_q <= ld_if.data_in;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Outputs only change here, so staging writes never leak to the core early.
                    word_q      <= assemble_word(stage_hi_q, stage_lo_q);
                    inst_done_q <= 1'b1;
                    lock_cnt_q  <= LOCK_LOAD;
                    state_q     <= LOCKOUT;
                end
                LOCKOUT: begin
                    if (lock_cnt_q == '0) begin
                        state_q <= WAIT_HI;
                    end else begin
                        lock_cnt_q <= lock_cnt_q - 1'b1;
                    end
                end
                default: state_q <= WAIT_HI;
            endcase
        end
    end

    assign ld_if.opcode    = word_q.opcode;
    assign ld_if.instr     = word_q.instr;
    assign ld_if.inst_done = inst_done_q;
    assign ld_if.btn_edge  = btn_edge;
    assign ld_if.busy      = (state_q == ISSUE) || (state_q == LOCKOUT);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a default-parameter instance for reset, bounce, load, stability and
// mid-load reset, plus a short-debounce instance so a press can land inside the lockout window.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int SLOW_LAT = 16 + 3;
    localparam int FAST_LAT = 2 + 3;
    localparam int LOCK_CYC = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       raw_s, raw_f;
    logic       use_fast;

    always #5 clk = ~clk;

    instr_loader_if bus_s ();
    instr_loader_if bus_f ();

    assign bus_s.data_in = data_in;
    assign bus_s.btn_raw = raw_s;
    assign bus_f.data_in = data_in;
    assign bus_f.btn_raw = raw_f;

    instr_loader #(.DEBOUNCE_CYCLES(16), .EXEC_LOCKOUT(24)) dut_s (
        .clk (clk), .rst_n (rst_n), .ld_if (bus_s)
    );
    instr_loader #(.DEBOUNCE_CYCLES(2), .EXEC_LOCKOUT(24)) dut_f (
        .clk (clk), .rst_n (rst_n), .ld_if (bus_f)
    );

    logic        cur_edge, cur_busy, cur_done;
    logic [3:0]  cur_opcode;
    logic [11:0] cur_instr;

    always_comb begin
        cur_edge   = use_fast ? bus_f.btn_edge  : bus_s.btn_edge;
        cur_busy   = use_fast ? bus_f.busy      : bus_s.busy;
        cur_done   = use_fast ? bus_f.inst_done : bus_s.inst_done;
        cur_opcode = use_fast ? bus_f.opcode    : bus_s.opcode;
        cur_instr  = use_fast ? bus_f.instr     : bus_s.instr;
    end

    int checks = 0;
    int errors = 0;
    int done_s = 0, done_f = 0, edge_s = 0;

    always @(negedge clk) begin
        if (bus_s.inst_done === 1'b1) done_s++;
        if (bus_f.inst_done === 1'b1) done_f++;
        if (bus_s.btn_edge === 1'b1)  edge_s++;
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [3:0]  exp_opcode;
        logic [11:0] exp_instr;
        logic        exp_rtype;
    } load_vec_t;

    load_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_raw(input logic v);
        if (use_fast) raw_f = v;
        else          raw_s = v;
    endtask

    function automatic int done_cnt();
        return use_fast ? done_f : done_s;
    endfunction

    // Raise the button with data on the switches; returns at the negedge where btn_edge is seen.
    task automatic press(input logic [7:0] d);
        int lat;
        data_in = d;
        set_raw(1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cur_edge && lat < 60);
        check("press_latency", lat, use_fast ? FAST_LAT : SLOW_LAT);
    endtask

    task automatic release_btn();
        set_raw(1'b0);
        repeat ((use_fast ? FAST_LAT : SLOW_LAT) + 3) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cur_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", cur_busy, 1'b0);
    endtask

    task automatic load(input logic [7:0] hi, input logic [7:0] lo);
        press(hi);
        release_btn();
        press(lo);
        release_btn();
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0, e0, n, edge_at, lat;
        logic busy_at_edge;

        vecs[0] = '{8'hA5, 8'h0F, 4'hA, 12'h50F, 1'b1};
        vecs[1] = '{8'h00, 8'hFF, 4'h0, 12'h0FF, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 4'hF, 12'hF01, 1'b1};
        vecs[3] = '{8'h6B, 8'hC4, 4'h6, 12'hBC4, 1'b0};

        rst_n = 1'b0; raw_s = 1'b0; raw_f = 1'b0; data_in = 8'h00; use_fast = 1'b0;

        // Reset held for three clocks
        repeat (3) @(negedge clk);
        check("rst_opcode", bus_s.opcode, 4'h0);
        check("rst_instr", bus_s.instr, 12'h000);
        check("rst_done", bus_s.inst_done, 1'b0);
        check("rst_edge", bus_s.btn_edge, 1'b0);
        check("rst_busy", bus_s.busy, 1'b0);
        check("rst_busy_fast", bus_f.busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_opcode", bus_s.opcode, 4'h0);
        check("post_rst_busy", bus_s.busy, 1'b0);
        check("post_rst_edges", edge_s, 0);

        // Bouncy first press carrying the HI byte 9A
        data_in = 8'h9A;
        e0 = edge_s;
        for (int i = 0; i < 5; i++) begin
            raw_s = 1'b1;
            repeat (3) @(negedge clk);
            raw_s = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("bounce_no_edge", edge_s - e0, 0);
        raw_s = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_s.btn_edge && lat < 60);
        check("bounce_latency", lat, 19);
        release_btn();
        check("bounce_one_edge", edge_s - e0, 1);
        check("bounce_not_busy", bus_s.busy, 1'b0);

        // LO byte 3C completes the load; inst_done two cycles after btn_edge
        d0 = done_s;
        press(8'h3C);
        @(negedge clk);
        check("issue_busy", bus_s.busy, 1'b1);
        check("issue_no_done_yet", bus_s.inst_done, 1'b0);
        @(negedge clk);
        check("load_done_pulse", bus_s.inst_done, 1'b1);
        check("load_opcode", bus_s.opcode, 4'h9);
        check("load_instr", bus_s.instr, 12'hA3C);
        @(negedge clk);
        check("load_done_one_cycle", bus_s.inst_done, 1'b0);
        release_btn();
        wait_idle();
        check("load_done_count", done_s - d0, 1);
        check("load_opcode_held", bus_s.opcode, 4'h9);
        check("load_instr_held", bus_s.instr, 12'hA3C);

        // Switch changes in WAIT_LO and LOCKOUT must not reach the outputs
        press(8'h77);
        release_btn();
        for (int i = 0; i < 6; i++) begin
            data_in = 8'(8'h13 * (i + 1));
            repeat (4) @(negedge clk);
        end
        check("stab_wait_lo_opcode", bus_s.opcode, 4'h9);
        check("stab_wait_lo_instr", bus_s.instr, 12'hA3C);
        check("stab_wait_lo_busy", bus_s.busy, 1'b0);
        press(8'h88);
        release_btn();
        data_in = 8'hEE;
        wait_idle();
        check("stab_lockout_opcode", bus_s.opcode, 4'h7);
        check("stab_lockout_instr", bus_s.instr, 12'h788);

        // Reset after the first byte aborts the partial load
        press(8'hF0);
        release_btn();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_opcode", bus_s.opcode, 4'h0);
        check("midrst_instr", bus_s.instr, 12'h000);
        d0 = done_s;
        press(8'h12);
        release_btn();
        check("midrst_no_done", done_s - d0, 0);
        press(8'h34);
        release_btn();
        wait_idle();
        check("midrst_done", done_s - d0, 1);
        check("midrst_opcode_new", bus_s.opcode, 4'h1);
        check("midrst_instr_new", bus_s.instr, 12'h234);

        // Table of ordinary loads
        for (int i = 0; i < 4; i++) begin
            d0 = done_s;
            load(vecs[i].hi, vecs[i].lo);
            check($sformatf("vec%0d_done", i), done_s - d0, 1);
            check($sformatf("vec%0d_opcode", i), bus_s.opcode, vecs[i].exp_opcode);
            check($sformatf("vec%0d_instr", i), bus_s.instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_rtype", i), is_rtype(bus_s.opcode), vecs[i].exp_rtype);
        end

        // Lockout on the short-debounce instance: press two cycles after inst_done
        use_fast = 1'b1;
        repeat (4) @(negedge clk);
        d0 = done_f;
        press(8'hC1);
        release_btn();
        press(8'h7E);
        raw_f = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lk_done_pulse", bus_f.inst_done, 1'b1);
        data_in = 8'h55;
        n = 0;
        edge_at = -1;
        busy_at_edge = 1'b0;
        while (bus_f.busy && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 2)  raw_f = 1'b1;
            if (n == 12) raw_f = 1'b0;
            if (bus_f.btn_edge) begin
                edge_at = n;
                busy_at_edge = bus_f.busy;
            end
        end
        check("lk_busy_cycles", n, LOCK_CYC);
        check("lk_edge_cycle", edge_at, 7);
        check("lk_busy_at_edge", busy_at_edge, 1'b1);
        check("lk_opcode", bus_f.opcode, 4'hC);
        check("lk_instr", bus_f.instr, 12'h17E);
        check("lk_done_count", done_f - d0, 1);
        repeat (8) @(negedge clk);
        d0 = done_cnt();
        load(8'h2B, 8'h4D);
        check("lk_after_done", done_cnt() - d0, 1);
        check("lk_after_opcode", cur_opcode, 4'h2);
        check("lk_after_instr", cur_instr, 12'hB4D);
        check("lk_after_done_low", cur_done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
